pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipeline control carrier and hazard unit for the 32-bit pipelined RISC core. It consumes the decoded control word that the `control` decoder produces for the instruction in ID, and carries that word through the ID/EX, EX/MEM and MEM/WB stage registers. It detects load-use hazards and inserts stalls and bubbles, applies flushes on jump or taken branch, and generates the EX-stage forwarding selects and the PC-source select for the fetch stage.

## Interface
- No parameters. Register index width is fixed at 5 bits, and ALUOp width at 3 bits.
- clk  in  1  core clock; all state updates on the rising edge.
- res  in  1  asynchronous, active-low reset. Every register clears immediately when res=0.
- id_alu_op  in  3  ALUOp from the decoder for the ID instruction.
- id_reg_dest, id_reg_write, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_jump  in  1 each  decoder control bits for the ID instruction.
- id_rs, id_rt, id_rd  in  5 each  register fields of the ID instruction.
- ex_zero  in  1  ALU zero flag of the instruction currently in EX.
- stall  out  1  combinational. Holds PC and IF/ID.
- flush_if_id  out  1  combinational. Zeroes the IF/ID register on the next edge.
- pc_sel  out  2  combinational. 00 = PC+4, 01 = branch target, 10 = jump target.
- ex_alu_op  out  3  registered EX control.
- ex_alu_src, ex_reg_dest, ex_mem_read, ex_mem_write, ex_branch  out  1 each  registered EX control.
- ex_rs, ex_rt  out  5 each  registered source indices.
- ex_wreg  out  5  EX destination; equals rd if reg_dest=1, else rt.
- mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  out  1 each  EX/MEM control.
- mem_wreg  out  5  EX/MEM destination.
- wb_reg_write, wb_mem_to_reg  out  1 each  MEM/WB control.
- wb_wreg  out  5  MEM/WB destination.
- fwd_a, fwd_b  out  2 each  combinational. 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.

## Operation
- **Control word propagation.** Each edge shifts the control word ID→EX→MEM→WB. Only the fields needed downstream are carried.
- **Destination register.** ex_wreg is latched as id_reg_dest ? id_rd : id_rt.
- **Bubble.** A bubble is an all-zero control word with destination 0. A bubble never writes the register file or memory.
- **Load-use hazard.**
  - Condition: ex_mem_read=1, ex_wreg≠0, and ex_wreg matches id_rs, or matches id_rt while rt is a source.
  - rt is a source when id_alu_src=0, id_mem_write=1, or id_branch=1.
  - Effect: stall=1 and a bubble enters EX on the next edge. MEM and WB advance normally.
- **Taken branch.**
  - Condition: ex_branch=1 and ex_zero=1.
  - Effect: pc_sel=01 and flush_if_id=1. A bubble enters EX on the next edge, squashing the ID instruction.
  - stall is forced to 0, and any ID jump is ignored.
- **Jump in ID.**
  - Applies when no branch is taken in EX.
  - Effect: pc_sel=10 and flush_if_id=1. The jump's own control word still enters EX.
  - If a load-use stall is active in the same cycle, the stall wins: pc_sel=00 and no flush. The jump is re-evaluated next cycle.
- **Priority order:** taken branch > load-use stall > jump > normal.
- **Forwarding for source A** (fwd_b is identical using ex_rt):
  - fwd_a=10 if mem_reg_write=1, mem_wreg≠0 and mem_wreg=ex_rs.
  - Otherwise fwd_a=01 if wb_reg_write=1, wb_wreg≠0 and wb_wreg=ex_rs.
  - Otherwise 00.
  - EX/MEM has priority when both stages match.
- **Register 0** never causes a hazard or a forward.

## Timing
- **Reset.** All stage registers and all registered outputs go to 0 asynchronously. The combinational outputs therefore evaluate to stall=0, flush_if_id=0, pc_sel=00, fwd_a=fwd_b=00.
- **Release.** Normal operation begins on the first rising edge after res deasserts.
- **Reset mid-operation** discards all in-flight control words. No partial write survives.
- **Latency.** A control word appears on ex_* 1 cycle after it is presented on id_*, on mem_* after 2 cycles, and on wb_* after 3 cycles.
- **Stall length.**
  - Exactly one cycle per load-use pair.
  - On the following cycle ex_mem_read=0 (bubble), so the stall self-clears.
  - The dependent instruction then receives fwd=01 from WB when it reaches EX.
- **Branch penalty.** Two squashed instructions:
  - the IF instruction, by flush;
  - the ID instruction, by bubble.
- **Jump penalty.** One squashed instruction.
- **Same-cycle updates.** Combinational outputs reflect stage-register contents in the same cycle. Registers update only on the rising clk edge.

## Test plan
- **Reset.** Hold res=0 for 7 ns with random id_* inputs -> every output is 0. On the first edge after release, ex_* equals the id_* word.
- **Load-use.** Put `lw` into EX (ex_mem_read=1, ex_wreg=5) and present id_rs=5 with id_alu_src=1 -> stall=1 for exactly one cycle. EX is then all-zero, and on the next cycle fwd_a=01.
- **Forwarding priority.** Two back-to-back R-type ops both write r3, then a consumer with rs=rt=3 -> fwd_a=fwd_b=10. With the nearer producer replaced by a write to r0 -> fwd=01.
- **Taken branch with conflicts.** ex_branch=1 and ex_zero=1, while ID holds a jump and a load-use match -> pc_sel=01, flush_if_id=1, stall=0, and ex_* is all-zero on the next edge.
- **Jump during stall.** id_jump=1 during a load-use stall -> pc_sel=00 that cycle, then pc_sel=10 and flush_if_id=1 on the following cycle.
- **Mid-stream reset.** Assert res=0 mid-stream while mem_reg_write=1 -> mem_reg_write and wb_reg_write drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Carries decoded control ID->EX->MEM->WB (1/2/3-cycle latency), detects load-use hazards,
// applies branch/jump flushes and drives forwarding and PC-source selects; stalls hold PC and IF/ID.
module pipe_ctrl_unit (
  input  logic       clk,
  input  logic       res,
  input  logic [2:0] id_alu_op,
  input  logic       id_reg_dest,
  input  logic       id_reg_write,
  input  logic       id_alu_src,
  input  logic       id_mem_read,
  input  logic       id_mem_write,
  input  logic       id_mem_to_reg,
  input  logic       id_branch,
  input  logic       id_jump,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       ex_zero,
  output logic       stall,
  output logic       flush_if_id,
  output logic [1:0] pc_sel,
  output logic [2:0] ex_alu_op,
  output logic       ex_alu_src,
  output logic       ex_reg_dest,
  output logic       ex_mem_read,
  output logic       ex_mem_write,
  output logic       ex_branch,
  output logic [4:0] ex_rs,
  output logic [4:0] ex_rt,
  output logic [4:0] ex_wreg,
  output logic       mem_mem_read,
  output logic       mem_mem_write,
  output logic       mem_reg_write,
  output logic       mem_mem_to_reg,
  output logic [4:0] mem_wreg,
  output logic       wb_reg_write,
  output logic       wb_mem_to_reg,
  output logic [4:0] wb_wreg,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dest;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
  } ex_word_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] wreg;
  } mem_word_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] wreg;
  } wb_word_t;

  ex_word_t  ex_q, ex_d;
  mem_word_t mem_q, mem_d;
  wb_word_t  wb_q, wb_d;

  logic rt_is_src, load_use, br_taken, jump_go;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input mem_word_t m, input wb_word_t w);
    if (m.reg_write && m.wreg != 5'd0 && m.wreg == src)      fwd_sel = 2'b10;
    else if (w.reg_write && w.wreg != 5'd0 && w.wreg == src) fwd_sel = 2'b01;
    else                                                     fwd_sel = 2'b00;
  endfunction

  always_comb begin
    rt_is_src   = ~id_alu_src | id_mem_write | id_branch;
    load_use    = ex_q.mem_read && (ex_q.wreg != 5'd0) &&
                  ((ex_q.wreg == id_rs) || (rt_is_src && (ex_q.wreg == id_rt)));
    br_taken    = ex_q.branch & ex_zero;
    // A stalled jump is not lost: ID is held and it is re-evaluated next cycle.
    jump_go     = id_jump & ~br_taken & ~load_use;
    stall       = load_use & ~br_taken;
    flush_if_id = br_taken | jump_go;
    pc_sel      = br_taken ? 2'b01 : (jump_go ? 2'b10 : 2'b00);
    fwd_a       = fwd_sel(ex_q.rs, mem_q, wb_q);
    fwd_b       = fwd_sel(ex_q.rt, mem_q, wb_q);
  end

  always_comb begin
    ex_d = '0;
    if (!(load_use || br_taken)) begin
      ex_d.alu_op     = id_alu_op;
      ex_d.alu_src    = id_alu_src;
      ex_d.reg_dest   = id_reg_dest;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.branch     = id_branch;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.wreg       = id_reg_dest ? id_rd : id_rt;
    end
    mem_d = '{mem_read: ex_q.mem_read, mem_write: ex_q.mem_write, reg_write: ex_q.reg_write,
              mem_to_reg: ex_q.mem_to_reg, wreg: ex_q.wreg};
    wb_d  = '{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg, wreg: mem_q.wreg};
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_alu_op      = ex_q.alu_op;
  assign ex_alu_src     = ex_q.alu_src;
  assign ex_reg_dest    = ex_q.reg_dest;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_branch      = ex_q.branch;
  assign ex_rs          = ex_q.rs;
  assign ex_rt          = ex_q.rt;
  assign ex_wreg        = ex_q.wreg;
  assign mem_mem_read   = mem_q.mem_read;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_reg_write  = mem_q.reg_write;
  assign mem_mem_to_reg = mem_q.mem_to_reg;
  assign mem_wreg       = mem_q.wreg;
  assign wb_reg_write   = wb_q.reg_write;
  assign wb_mem_to_reg  = wb_q.mem_to_reg;
  assign wb_wreg        = wb_q.wreg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed hazard scenarios plus random instruction streams
// checked against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

  logic       clk, res;
  logic [2:0] id_alu_op;
  logic       id_reg_dest, id_reg_write, id_alu_src, id_mem_read, id_mem_write;
  logic       id_mem_to_reg, id_branch, id_jump;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero;
  logic       stall, flush_if_id;
  logic [1:0] pc_sel, fwd_a, fwd_b;
  logic [2:0] ex_alu_op;
  logic       ex_alu_src, ex_reg_dest, ex_mem_read, ex_mem_write, ex_branch;
  logic [4:0] ex_rs, ex_rt, ex_wreg;
  logic       mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
  logic [4:0] mem_wreg;
  logic       wb_reg_write, wb_mem_to_reg;
  logic [4:0] wb_wreg;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl_unit dut (
    .clk(clk), .res(res),
    .id_alu_op(id_alu_op), .id_reg_dest(id_reg_dest), .id_reg_write(id_reg_write),
    .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_jump(id_jump),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .stall(stall), .flush_if_id(flush_if_id), .pc_sel(pc_sel),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_dest(ex_reg_dest),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_wreg(mem_wreg),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_wreg(wb_wreg),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one full instruction record per stage, shifted whole each cycle.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src, reg_dest, mem_read, mem_write, branch, reg_write, mem_to_reg;
    logic [4:0] rs, rt, wreg;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;

  function automatic instr_t id_instr();
    instr_t w;
    w.alu_op = id_alu_op;       w.alu_src = id_alu_src;     w.reg_dest = id_reg_dest;
    w.mem_read = id_mem_read;   w.mem_write = id_mem_write; w.branch = id_branch;
    w.reg_write = id_reg_write; w.mem_to_reg = id_mem_to_reg;
    w.rs = id_rs; w.rt = id_rt; w.wreg = id_reg_dest ? id_rd : id_rt;
    return w;
  endfunction

  function automatic bit m_taken();
    return m_ex.branch && ex_zero;
  endfunction

  function automatic bit m_load_use();
    bit reads_rt;
    reads_rt = !id_alu_src || id_mem_write || id_branch;
    if (!m_ex.mem_read || m_ex.wreg == 0) return 0;
    return (m_ex.wreg == id_rs) || (reads_rt && m_ex.wreg == id_rt);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (m_mem.reg_write && m_mem.wreg == src) return 2'b10;
    if (m_wb.reg_write && m_wb.wreg == src) return 2'b01;
    return 2'b00;
  endfunction

  // {stall, flush_if_id, pc_sel, fwd_a, fwd_b}
  function automatic logic [7:0] exp_comb();
    logic [3:0] ctl;
    if (m_taken())         ctl = 4'b0101;
    else if (m_load_use()) ctl = 4'b1000;
    else if (id_jump)      ctl = 4'b0110;
    else                   ctl = 4'b0000;
    return {ctl, m_fwd(m_ex.rs), m_fwd(m_ex.rt)};
  endfunction

  function automatic logic [38:0] exp_regs();
    return {m_ex.alu_op, m_ex.alu_src, m_ex.reg_dest, m_ex.mem_read, m_ex.mem_write,
            m_ex.branch, m_ex.rs, m_ex.rt, m_ex.wreg,
            m_mem.mem_read, m_mem.mem_write, m_mem.reg_write, m_mem.mem_to_reg, m_mem.wreg,
            m_wb.reg_write, m_wb.mem_to_reg, m_wb.wreg};
  endfunction

  wire [7:0]  dut_comb = {stall, flush_if_id, pc_sel, fwd_a, fwd_b};
  wire [38:0] dut_regs = {ex_alu_op, ex_alu_src, ex_reg_dest, ex_mem_read, ex_mem_write,
                          ex_branch, ex_rs, ex_rt, ex_wreg,
                          mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_wreg,
                          wb_reg_write, wb_mem_to_reg, wb_wreg};
  wire [22:0] dut_ex   = {ex_alu_op, ex_alu_src, ex_reg_dest, ex_mem_read, ex_mem_write,
                          ex_branch, ex_rs, ex_rt, ex_wreg};

  task automatic tick();
    bit     bubble;
    instr_t w;
    bubble = m_taken() || m_load_use();
    w = id_instr();
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = bubble ? '0 : w;
    #1;
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
  endtask

  task automatic drive_id(input logic [2:0] op, input logic rdst, rw, asrc, mr, mw, m2r, br, jmp,
                          input logic [4:0] rs, rt, rd);
    id_alu_op = op; id_reg_dest = rdst; id_reg_write = rw; id_alu_src = asrc;
    id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r; id_branch = br; id_jump = jmp;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic random_id(input int reg_max);
    logic [7:0] b;
    b = 8'($urandom);
    drive_id(3'($urandom), b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7] & ($urandom_range(0, 2) == 0),
             5'($urandom_range(0, reg_max)), 5'($urandom_range(0, reg_max)),
             5'($urandom_range(0, reg_max)));
  endtask

  task automatic drain();
    drive_id(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    ex_zero = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [22:0] want_ex;
    res = 1'b0;
    random_id(31);
    ex_zero = 1'($urandom);
    #6;
    n_vec++;
    if (dut_comb !== 8'd0) begin
      n_err++; $display("FAIL reset_comb got %h exp 00", dut_comb);
    end
    n_vec++;
    if (dut_regs !== 39'd0) begin
      n_err++; $display("FAIL reset_regs got %h exp 0", dut_regs);
    end
    #1 res = 1'b1;
    model_reset();
    want_ex = {id_alu_op, id_alu_src, id_reg_dest, id_mem_read, id_mem_write, id_branch,
               id_rs, id_rt, (id_reg_dest ? id_rd : id_rt)};
    tick();
    n_vec++;
    if (dut_ex !== want_ex) begin
      n_err++; $display("FAIL release_ex got %h exp %h", dut_ex, want_ex);
    end
  endtask

  task automatic test_load_use();
    drain();
    drive_id(3'd0, 0, 1, 1, 1, 0, 1, 0, 0, 5'd1, 5'd5, 5'd0);
    tick();
    n_vec++;
    if ({ex_mem_read, ex_wreg} !== {1'b1, 5'd5}) begin
      n_err++; $display("FAIL lu_lw_in_ex got %b/%0d exp 1/5", ex_mem_read, ex_wreg);
    end
    drive_id(3'd2, 1, 1, 1, 0, 0, 0, 0, 0, 5'd5, 5'd9, 5'd7);
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL lu_stall got %b exp 1", stall);
    end
    tick();
    n_vec++;
    if ({stall, dut_ex} !== 24'd0) begin
      n_err++; $display("FAIL lu_bubble got stall=%b ex=%h exp 0/0", stall, dut_ex);
    end
    tick();
    n_vec++;
    if ({fwd_a, ex_rs, ex_wreg} !== {2'b01, 5'd5, 5'd7}) begin
      n_err++; $display("FAIL lu_fwd got fwd_a=%b rs=%0d wreg=%0d exp 01/5/7", fwd_a, ex_rs, ex_wreg);
    end
  endtask

  task automatic test_fwd_priority();
    for (int c = 0; c < 2; c++) begin
      logic [4:0] near_rd;
      logic [3:0] want;
      near_rd = (c == 0) ? 5'd3 : 5'd0;
      want    = (c == 0) ? 4'b1010 : 4'b0101;
      drain();
      drive_id(3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
      tick();
      drive_id(3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, near_rd);
      tick();
      drive_id(3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3, 5'd4);
      tick();
      n_vec++;
      if ({fwd_a, fwd_b} !== want) begin
        n_err++; $display("FAIL fwd_prio_%0d got %b exp %b", c, {fwd_a, fwd_b}, want);
      end
    end
  endtask

  task automatic test_branch_conflict();
    drain();
    drive_id(3'd1, 0, 0, 0, 1, 0, 0, 1, 0, 5'd2, 5'd6, 5'd0);
    tick();
    drive_id(3'd0, 0, 0, 1, 0, 0, 0, 0, 1, 5'd6, 5'd0, 5'd0);
    ex_zero = 1'b1;
    #1;
    n_vec++;
    if ({pc_sel, flush_if_id, stall} !== 4'b0110) begin
      n_err++; $display("FAIL br_taken got pc=%b fl=%b st=%b exp 01/1/0", pc_sel, flush_if_id, stall);
    end
    tick();
    ex_zero = 1'b0;
    n_vec++;
    if (dut_ex !== 23'd0) begin
      n_err++; $display("FAIL br_squash got %h exp 0", dut_ex);
    end
  endtask

  task automatic test_jump_stall();
    drain();
    drive_id(3'd0, 0, 1, 1, 1, 0, 1, 0, 0, 5'd1, 5'd5, 5'd0);
    tick();
    drive_id(3'd0, 0, 0, 1, 0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd0);
    #1;
    n_vec++;
    if ({pc_sel, flush_if_id, stall} !== 4'b0001) begin
      n_err++; $display("FAIL jmp_stalled got pc=%b fl=%b st=%b exp 00/0/1", pc_sel, flush_if_id, stall);
    end
    tick();
    n_vec++;
    if ({pc_sel, flush_if_id, stall} !== 4'b1010) begin
      n_err++; $display("FAIL jmp_after got pc=%b fl=%b st=%b exp 10/1/0", pc_sel, flush_if_id, stall);
    end
  endtask

  task automatic test_midstream_reset();
    drain();
    drive_id(3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd8);
    tick();
    drive_id(3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd9);
    tick();
    n_vec++;
    if (mem_reg_write !== 1'b1) begin
      n_err++; $display("FAIL mid_pre got mem_reg_write=%b exp 1", mem_reg_write);
    end
    #2 res = 1'b0;
    #1;
    n_vec++;
    if ({mem_reg_write, wb_reg_write, dut_regs} !== 41'd0) begin
      n_err++; $display("FAIL mid_reset got mrw=%b wrw=%b regs=%h exp 0", mem_reg_write, wb_reg_write, dut_regs);
    end
    #1 res = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_id((i < 200) ? 3 : 31);
      ex_zero = 1'($urandom);
      #1;
      n_vec++;
      if (dut_comb !== exp_comb()) begin
        n_err++; $display("FAIL rand_comb[%0d] got %b exp %b", i, dut_comb, exp_comb());
      end
      n_vec++;
      if (dut_regs !== exp_regs()) begin
        n_err++; $display("FAIL rand_regs[%0d] got %h exp %h", i, dut_regs, exp_regs());
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_branch_conflict();
    test_jump_stall();
    test_midstream_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
